// File: rtl/hififo_arb_pkg.sv
// Shared definitions for the to-PC FIFO arbiter.
//   arb_state_e : arbiter FSM states (HEADER only reachable with
//                 TPC_ARBITER_HEADER_EN defined)
//   HDR_TAG     : tag byte placed in [63:56] of a grant header word
//   GID_W       : width of grant_id / round-robin pointer
package hififo_arb_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    BURST  = 2'd2
  } arb_state_e;

  localparam logic [7:0] HDR_TAG = 8'hA5;
  localparam int         GID_W   = 3;
endpackage

// File: rtl/tpc_arbiter_rr_pick.sv
// rr_pick: combinational round-robin priority encoder.
//   req [N-1:0]    : request vector
//   ptr [GID_W-1:0]: index with highest priority this cycle (0..N-1)
//   idx [GID_W-1:0]: first set request found scanning ptr, ptr+1, ... mod N
//   any            : at least one request set (idx is 0 when clear)
module rr_pick
  import hififo_arb_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]     req,
  input  logic [GID_W-1:0] ptr,
  output logic [GID_W-1:0] idx,
  output logic             any
);
  localparam int SEL_W = $clog2(N);

  logic [SEL_W-1:0] j;

  // Scan from the farthest slot back towards ptr so the closest hit wins.
  always_comb begin
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = SEL_W'((int'(ptr) + k) % N);
      if (req[j]) begin
        idx = GID_W'(j);
        any = 1'b1;
      end
    end
  end
endmodule

// File: rtl/tpc_arbiter.sv
// tpc_arbiter: round-robin arbiter merging N requester bursts into one
// to-PC FIFO write port. A grant lasts until a word with req_last or the
// MAX_BURST-th word; bursts never interleave.
// Optional feature: define TPC_ARBITER_HEADER_EN to prefix every grant
// with a header word {8'hA5, 8'(grant_id), 48'h0}.
// Ports:
//   clock, reset_n       : rising-edge clock, async active-low reset
//   req_valid/data/last  : per-requester word, valid and end-of-burst flag
//   req_ready            : per-requester accept (valid & ready = taken)
//   tpc_ready            : FIFO has room for at least 2 more words
//   tpc_write, tpc_data  : registered FIFO write strobe and data
//   grant_id             : current or most recent grant
module tpc_arbiter
  import hififo_arb_pkg::*;
#(
  parameter int N         = 4,
  parameter int MAX_BURST = 64
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N-1:0][63:0]   req_data,
  input  logic [N-1:0]         req_last,
  output logic [N-1:0]         req_ready,
  input  logic                 tpc_ready,
  output logic                 tpc_write,
  output logic [63:0]          tpc_data,
  output logic [GID_W-1:0]     grant_id
);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;
  localparam int SEL_W = $clog2(N);

  arb_state_e       state_q, state_d;
  logic [GID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [GID_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tpc_write_q, tpc_write_d;
  logic [63:0]      tpc_data_q, tpc_data_d;

  logic [GID_W-1:0] pick_idx;
  logic             pick_any;
  logic [SEL_W-1:0] gsel;
  logic             xfer;
  logic             burst_end;

  rr_pick #(.N(N)) u_pick (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign gsel      = grant_q[SEL_W-1:0];
  assign xfer      = (state_q == BURST) && req_valid[gsel] && tpc_ready;
  // cnt_q counts words already taken, so MAX_BURST-1 means this is the last.
  assign burst_end = xfer && (req_last[gsel] || cnt_q == CNT_W'(MAX_BURST - 1));

  assign tpc_write = tpc_write_q;
  assign tpc_data  = tpc_data_q;
  assign grant_id  = grant_q;

  always_comb begin
    req_ready = '0;
    if (state_q == BURST) req_ready[gsel] = tpc_ready;
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_d     = grant_q;
    cnt_d       = cnt_q;
    tpc_write_d = 1'b0;
    tpc_data_d  = tpc_data_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          cnt_d   = '0;
`ifdef TPC_ARBITER_HEADER_EN
          state_d = HEADER;
`else
          state_d = BURST;
`endif
        end
      end
`ifdef TPC_ARBITER_HEADER_EN
      // Header uses a FIFO slot, so it waits for tpc_ready like a data word.
      HEADER: begin
        if (tpc_ready) begin
          tpc_write_d = 1'b1;
          tpc_data_d  = {HDR_TAG, 8'(grant_q), 48'd0};
          state_d     = BURST;
        end
      end
`endif
      BURST: begin
        if (xfer) begin
          tpc_write_d = 1'b1;
          tpc_data_d  = req_data[gsel];
          cnt_d       = cnt_q + CNT_W'(1);
          if (burst_end) begin
            state_d  = IDLE;
            rr_ptr_d = GID_W'((int'(grant_q) + 1) % N);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_q     <= '0;
      cnt_q       <= '0;
      tpc_write_q <= 1'b0;
      tpc_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_q     <= grant_d;
      cnt_q       <= cnt_d;
      tpc_write_q <= tpc_write_d;
      tpc_data_q  <= tpc_data_d;
    end
  end
endmodule

// File: tb/tb_tpc_arbiter.sv
// Self-checking bench for tpc_arbiter (N=4, MAX_BURST=64).
// Requesters are modelled as word queues; a reference model keeps its own
// copy of every queue plus a round-robin pointer and predicts, word by word,
// which requester owns each burst and what lands in the FIFO.
module tb_tpc_arbiter;
  import hififo_arb_pkg::*;

  localparam int N    = 4;
  localparam int MAXB = 64;

  logic                clock = 1'b0;
  logic                reset_n = 1'b0;
  logic [N-1:0]        req_valid = '0;
  logic [N-1:0][63:0]  req_data = '0;
  logic [N-1:0]        req_last = '0;
  logic [N-1:0]        req_ready;
  logic                tpc_ready = 1'b1;
  logic                tpc_write;
  logic [63:0]         tpc_data;
  logic [GID_W-1:0]    grant_id;

  always #5 clock = ~clock;

  tpc_arbiter #(.N(N), .MAX_BURST(MAXB)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .tpc_ready (tpc_ready),
    .tpc_write (tpc_write),
    .tpc_data  (tpc_data),
    .grant_id  (grant_id)
  );

  typedef struct packed {
    logic [63:0] d;
    logic        l;
  } word_t;

  typedef struct {
    logic [N-1:0] mask;
    int           exp_first;
  } vec_t;

  word_t       dq[N][$];     // what the requesters still have to offer
  word_t       mq[N][$];     // model's copy, consumed as words reach the FIFO
  int          blen[N][$];   // burst lengths seen per requester
  int          starts[$];    // grant_id at the first FIFO word of each burst
  int          seqc[N];
  int          n_chk = 0, n_fail = 0;
  int          mptr = 0, cur = 0, mcnt = 0;
  bit          in_burst = 0;
  logic [63:0] prev_data = '0;
  logic        obs_wr;
  logic [N-1:0] obs_rr;
  int          rdy_mode = 1;  // 0 random, 1 high, 2 low

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic void model_reset();
    mptr = 0; cur = 0; mcnt = 0; in_burst = 0; prev_data = '0;
    for (int i = 0; i < N; i++) begin
      dq[i].delete();
      mq[i].delete();
    end
  endfunction

  function automatic void model_word(logic [63:0] d, logic [GID_W-1:0] gid);
    word_t w;
    if (!in_burst) begin
      int pick;
      pick = -1;
      for (int k = N - 1; k >= 0; k--)
        if (mq[(mptr + k) % N].size() != 0) pick = (mptr + k) % N;
      if (pick < 0) begin
        n_chk++; n_fail++;
        $display("FAIL spurious_write: data %0h with no pending word", d);
        return;
      end
      cur = pick; in_burst = 1; mcnt = 0;
      starts.push_back(int'(gid));
`ifdef TPC_ARBITER_HEADER_EN
      chk("header_word", d, {8'hA5, 8'(pick), 48'd0});
      chk("header_gid", 64'(gid), 64'(pick));
      return;
`endif
    end
    chk("grant_id", 64'(gid), 64'(cur));
    if (mq[cur].size() == 0) begin
      n_chk++; n_fail++;
      $display("FAIL extra_word: got %0h from requester %0d with none left", d, cur);
      return;
    end
    w = mq[cur].pop_front();
    chk("data", d, w.d);
    mcnt++;
    if (w.l || mcnt == MAXB) begin
      in_burst = 0;
      mptr = (cur + 1) % N;
      blen[cur].push_back(mcnt);
    end
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (dq[i].size() != 0) begin
        req_valid[i] = 1'b1; req_data[i] = dq[i][0].d; req_last[i] = dq[i][0].l;
      end else begin
        req_valid[i] = 1'b0; req_data[i] = '0; req_last[i] = 1'b0;
      end
    end
    case (rdy_mode)
      0:       tpc_ready = ($urandom_range(3) != 0);
      1:       tpc_ready = 1'b1;
      default: tpc_ready = 1'b0;
    endcase
  endtask

  task automatic cycle();
    logic [N-1:0] fire;
    @(negedge clock);
    fire   = req_valid & req_ready;
    obs_wr = tpc_write;
    obs_rr = req_ready;
    if (tpc_write) model_word(tpc_data, grant_id);
    else chk("data_hold", tpc_data, prev_data);
    prev_data = tpc_data;
    @(posedge clock); #1;
    for (int i = 0; i < N; i++)
      if (fire[i]) void'(dq[i].pop_front());
    drive();
  endtask

  task automatic add_burst(int r, int len);
    word_t w;
    for (int k = 0; k < len; k++) begin
      w.d = {8'(r), 24'(seqc[r]), 32'($urandom)};
      w.l = (k == len - 1);
      seqc[r]++;
      dq[r].push_back(w);
      mq[r].push_back(w);
    end
  endtask

  function automatic bit busy();
    busy = in_burst;
    for (int i = 0; i < N; i++) if (dq[i].size() != 0) busy = 1;
  endfunction

  task automatic drain(string name, int max);
    int n;
    n = 0;
    while (busy() && n < max) begin
      cycle();
      n++;
    end
    if (n >= max) begin
      n_chk++; n_fail++;
      $display("FAIL timeout_%s: ran %0d cycles, limit %0d", name, n, max);
    end
    cycle();
    cycle();
    for (int i = 0; i < N; i++) chk({"drained_", name}, 64'(mq[i].size()), 64'd0);
  endtask

  task automatic wait_word(int r, int cnt, string name);
    int n;
    n = 0;
    while (!(in_burst && cur == r && mcnt == cnt) && n < 200) begin
      cycle();
      n++;
    end
    if (n >= 200) begin
      n_chk++; n_fail++;
      $display("FAIL timeout_%s: word %0d of requester %0d never seen", name, cnt, r);
    end
  endtask

  vec_t tbl[7];
  int   hdr;

  initial begin
`ifdef TPC_ARBITER_HEADER_EN
    hdr = 1;
`else
    hdr = 0;
`endif
    // Expected first grant after loading single-word bursts into mask.
    tbl[0] = '{4'b1111, 0};
    tbl[1] = '{4'b1111, 0};
    tbl[2] = '{4'b0100, 2};
    tbl[3] = '{4'b0011, 0};
    tbl[4] = '{4'b1010, 3};
    tbl[5] = '{4'b0001, 0};
    tbl[6] = '{4'b1001, 3};
    for (int i = 0; i < N; i++) seqc[i] = 0;

    // Reset state, with requests pending to make req_ready meaningful.
    req_valid = '1;
    #12;
    chk("rst_write", 64'(tpc_write), 64'd0);
    chk("rst_data", tpc_data, 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd0);
    req_valid = '0;
    @(posedge clock); #1;
    reset_n = 1'b1;
    drive();

    // Round-robin table.
    for (int t = 0; t < 7; t++) begin
      starts.delete();
      for (int i = 0; i < N; i++) if (tbl[t].mask[i]) add_burst(i, 1);
      drive();
      drain("tbl", 200);
      chk("tbl_first_grant", (starts.size() > 0) ? 64'(starts[0]) : '1, 64'(tbl[t].exp_first));
      if (t == 0) begin
        chk("rr_order_len", 64'(starts.size()), 64'd4);
        if (starts.size() == 4)
          for (int j = 0; j < 4; j++) chk("rr_order", 64'(starts[j]), 64'(j));
      end
    end

    // Single requester latency: writes start 2 cycles after valid.
    starts.delete();
    rdy_mode = 1;
    add_burst(2, 3);
    drive();
    for (int k = 1; k <= 7; k++) begin
      cycle();
      chk($sformatf("lat_wr_%0d", k), 64'(obs_wr), 64'(k >= 3 && k <= 5 + hdr));
    end
    drain("lat", 50);
    chk("lat_grant", (starts.size() > 0) ? 64'(starts[0]) : '1, 64'd2);

    // Long stream split at MAX_BURST with others served in between.
    for (int i = 0; i < N; i++) blen[i].delete();
    starts.delete();
    add_burst(1, 200);
    add_burst(0, 1); add_burst(0, 1); add_burst(0, 1);
    add_burst(3, 2);
    rdy_mode = 0;
    drive();
    drain("maxburst", 3000);
    chk("mb_count", 64'(blen[1].size()), 64'd4);
    if (blen[1].size() == 4) begin
      chk("mb_len0", 64'(blen[1][0]), 64'd64);
      chk("mb_len1", 64'(blen[1][1]), 64'd64);
      chk("mb_len2", 64'(blen[1][2]), 64'd64);
      chk("mb_len3", 64'(blen[1][3]), 64'd8);
    end
    chk("mb_starts_len", 64'(starts.size()), 64'd8);
    if (starts.size() == 8) begin
      int exp_s[8];
      exp_s = '{3, 0, 1, 0, 1, 0, 1, 1};
      for (int j = 0; j < 8; j++) chk("mb_order", 64'(starts[j]), 64'(exp_s[j]));
    end

    // Stall mid-burst for 5 cycles.
    rdy_mode = 1;
    add_burst(2, 20);
    drive();
    wait_word(2, 5, "stall");
    rdy_mode = 2;
    drive();
    for (int s = 1; s <= 5; s++) begin
      cycle();
      chk("stall_rr", 64'(obs_rr), 64'd0);
      if (s >= 2) chk("stall_wr", 64'(obs_wr), 64'd0);
    end
    chk("stall_cnt", 64'(mcnt), 64'd6);
    rdy_mode = 1;
    drive();
    drain("stall", 100);
    chk("stall_len", (blen[2].size() > 0) ? 64'(blen[2][$]) : '1, 64'd20);

    // Reset mid-burst: pointer left at 1 beforehand, fresh scan from 0 after.
    add_burst(0, 1);
    drive();
    drain("pre_rst", 50);
    add_burst(1, 30);
    drive();
    wait_word(1, 10, "rst");
    reset_n = 1'b0;
    #1;
    chk("mid_rst_write", 64'(tpc_write), 64'd0);
    chk("mid_rst_data", tpc_data, 64'd0);
    chk("mid_rst_grant", 64'(grant_id), 64'd0);
    chk("mid_rst_ready", 64'(req_ready), 64'd0);
    model_reset();
    drive();
    @(negedge clock);
    chk("mid_rst_write2", 64'(tpc_write), 64'd0);
    chk("mid_rst_data2", tpc_data, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    starts.delete();
    add_burst(3, 2);
    add_burst(0, 2);
    drive();
    drain("post_rst", 100);
    chk("post_rst_n", 64'(starts.size()), 64'd2);
    if (starts.size() == 2) begin
      chk("post_rst_first", 64'(starts[0]), 64'd0);
      chk("post_rst_second", 64'(starts[1]), 64'd3);
    end

    // Randomized traffic with random back-pressure.
    rdy_mode = 0;
    for (int i = 0; i < N; i++)
      for (int b = 0; b < 3; b++) add_burst(i, $urandom_range(70, 1));
    drive();
    drain("random", 20000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
